// File: rtl/ra_net_interface.sv
// ra_net_interface
// Serializes one remote read/write request into a head/address[/data] packet
// on the router injection port, then collects and checks the matching response
// packet from the ejection port and returns read data to the core.
// Only one transaction is in flight at a time.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   core2net_dRead/dWrite/dAddr/dData   request from the remote-access splitter
//   net2core_dReady/dValid/dAddr/dData  request ready and read-return path
//   tx_flit/tx_valid/tx_ready    injection port, flit = {type[1:0], payload}
//   rx_flit/rx_valid/rx_ready    ejection port
//   proto_err                    sticky malformed/mismatched response flag
module ra_net_interface #(
    parameter int CORE           = 0,
    parameter int ID_BITS        = 4,
    parameter int REAL_ADDR_BITS = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_BITS   = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    core2net_dRead,
    input  logic                    core2net_dWrite,
    input  logic [ADDRESS_BITS-1:0] core2net_dAddr,
    input  logic [DATA_WIDTH-1:0]   core2net_dData,
    output logic                    net2core_dReady,
    output logic                    net2core_dValid,
    output logic [ADDRESS_BITS-1:0] net2core_dAddr,
    output logic [DATA_WIDTH-1:0]   net2core_dData,
    output logic [DATA_WIDTH+1:0]   tx_flit,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [DATA_WIDTH+1:0]   rx_flit,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    proto_err
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] HEAD      = 3'd1;
    localparam logic [2:0] ADDR      = 3'd2;
    localparam logic [2:0] DATA      = 3'd3;
    localparam logic [2:0] WAIT_RESP = 3'd4;

    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_BODY = 2'b00;
    localparam logic [1:0] FT_TAIL = 2'b10;

    localparam logic [1:0] OP_RD_REQ  = 2'b01;
    localparam logic [1:0] OP_WR_REQ  = 2'b10;
    localparam logic [1:0] OP_RD_RESP = 2'b11;
    localparam logic [1:0] OP_WR_ACK  = 2'b00;

    localparam logic [ID_BITS-1:0] CORE_ID = ID_BITS'(CORE);

    // Build a head flit addressed to dest, sourced from this core.
    function automatic logic [DATA_WIDTH+1:0] make_head(input logic [ID_BITS-1:0] dest,
                                                         input logic [1:0] opcode);
        logic [DATA_WIDTH-1:0] payload;
        payload = {DATA_WIDTH{1'b0}};
        payload[ID_BITS-1:0]             = dest;
        payload[2*ID_BITS-1:ID_BITS]     = CORE_ID;
        payload[2*ID_BITS+1:2*ID_BITS]   = opcode;
        return {FT_HEAD, payload};
    endfunction

    // A response head must come back to us, from the core we asked, with the right opcode.
    function automatic logic head_ok(input logic [DATA_WIDTH-1:0] payload,
                                     input logic [ID_BITS-1:0] dest,
                                     input logic is_write);
        return (payload[ID_BITS-1:0] == CORE_ID) &&
               (payload[2*ID_BITS-1:ID_BITS] == dest) &&
               (payload[2*ID_BITS+1:2*ID_BITS] == (is_write ? OP_WR_ACK : OP_RD_RESP));
    endfunction

    logic [2:0]              state_r, state_s;
    logic                    op_write_r, op_write_s;
    logic [ADDRESS_BITS-1:0] addr_r, addr_s;
    logic [DATA_WIDTH-1:0]   data_r, data_s;
    logic [ID_BITS-1:0]      dest_r, dest_s;
    logic [1:0]              rx_pos_r, rx_pos_s;     // 0 head, 1 address, 2 data
    logic                    discard_r, discard_s;   // dropping a bad packet up to its tail
    logic [ADDRESS_BITS-1:0] resp_addr_r, resp_addr_s;
    logic [DATA_WIDTH+1:0]   tx_flit_r, tx_flit_s;
    logic                    tx_valid_r, rx_ready_r, ready_r;
    logic                    dvalid_r, dvalid_s;
    logic [ADDRESS_BITS-1:0] daddr_r, daddr_s;
    logic [DATA_WIDTH-1:0]   ddata_r, ddata_s;
    logic                    proto_err_r, proto_err_s;

    logic                    tx_fire_s, rx_fire_s;
    logic [1:0]              rx_type_s;
    logic [DATA_WIDTH-1:0]   rx_pay_s;

    assign tx_fire_s = tx_valid_r & tx_ready;
    assign rx_fire_s = rx_ready_r & rx_valid;
    assign rx_type_s = rx_flit[DATA_WIDTH+1:DATA_WIDTH];
    assign rx_pay_s  = rx_flit[DATA_WIDTH-1:0];

    // Next-state, next-flit and response-checking decode.
    always_comb begin
        state_s     = state_r;
        op_write_s  = op_write_r;
        addr_s      = addr_r;
        data_s      = data_r;
        dest_s      = dest_r;
        rx_pos_s    = rx_pos_r;
        discard_s   = discard_r;
        resp_addr_s = resp_addr_r;
        tx_flit_s   = tx_flit_r;
        dvalid_s    = 1'b0;
        daddr_s     = daddr_r;
        ddata_s     = ddata_r;
        proto_err_s = proto_err_r;
        case (state_r)
            IDLE: begin
                if (core2net_dRead || core2net_dWrite) begin
                    // Write wins when both strobes are set.
                    op_write_s = core2net_dWrite;
                    addr_s     = core2net_dAddr;
                    data_s     = core2net_dData;
                    dest_s     = core2net_dAddr[REAL_ADDR_BITS+ID_BITS-1:REAL_ADDR_BITS];
                    tx_flit_s  = make_head(core2net_dAddr[REAL_ADDR_BITS+ID_BITS-1:REAL_ADDR_BITS],
                                           core2net_dWrite ? OP_WR_REQ : OP_RD_REQ);
                    state_s    = HEAD;
                end else begin
                    tx_flit_s = {(DATA_WIDTH+2){1'b0}};
                end
            end
            HEAD: begin
                if (tx_fire_s) begin
                    tx_flit_s = {(op_write_r ? FT_BODY : FT_TAIL), DATA_WIDTH'(addr_r)};
                    state_s   = ADDR;
                end else begin
                    state_s = HEAD;
                end
            end
            ADDR: begin
                if (tx_fire_s && op_write_r) begin
                    tx_flit_s = {FT_TAIL, data_r};
                    state_s   = DATA;
                end else if (tx_fire_s) begin
                    tx_flit_s = {(DATA_WIDTH+2){1'b0}};
                    rx_pos_s  = 2'd0;
                    discard_s = 1'b0;
                    state_s   = WAIT_RESP;
                end else begin
                    state_s = ADDR;
                end
            end
            DATA: begin
                if (tx_fire_s) begin
                    tx_flit_s = {(DATA_WIDTH+2){1'b0}};
                    rx_pos_s  = 2'd0;
                    discard_s = 1'b0;
                    state_s   = WAIT_RESP;
                end else begin
                    state_s = DATA;
                end
            end
            WAIT_RESP: begin
                if (rx_fire_s && discard_r) begin
                    // Bad packet: swallow everything through its tail.
                    if (rx_type_s == FT_TAIL) begin
                        discard_s = 1'b0;
                        rx_pos_s  = 2'd0;
                    end else begin
                        discard_s = 1'b1;
                    end
                end else if (rx_fire_s) begin
                    case (rx_pos_r)
                        2'd0: begin
                            if (rx_type_s != FT_HEAD) begin
                                // A stray tail already ends its own packet.
                                proto_err_s = 1'b1;
                                discard_s   = (rx_type_s != FT_TAIL);
                            end else if (!head_ok(rx_pay_s, dest_r, op_write_r)) begin
                                proto_err_s = 1'b1;
                                discard_s   = 1'b1;
                            end else begin
                                rx_pos_s = 2'd1;
                            end
                        end
                        2'd1: begin
                            if (rx_type_s != (op_write_r ? FT_TAIL : FT_BODY)) begin
                                proto_err_s = 1'b1;
                                discard_s   = (rx_type_s != FT_TAIL);
                                rx_pos_s    = 2'd0;
                            end else begin
                                if (ADDRESS_BITS'(rx_pay_s) != addr_r) begin
                                    proto_err_s = 1'b1;
                                end else begin
                                    proto_err_s = proto_err_r;
                                end
                                resp_addr_s = ADDRESS_BITS'(rx_pay_s);
                                if (op_write_r) begin
                                    rx_pos_s = 2'd0;
                                    state_s  = IDLE;
                                end else begin
                                    rx_pos_s = 2'd2;
                                end
                            end
                        end
                        2'd2: begin
                            if (rx_type_s != FT_TAIL) begin
                                proto_err_s = 1'b1;
                                discard_s   = 1'b1;
                                rx_pos_s    = 2'd0;
                            end else begin
                                daddr_s  = resp_addr_r;
                                ddata_s  = rx_pay_s;
                                dvalid_s = 1'b1;
                                rx_pos_s = 2'd0;
                                state_s  = IDLE;
                            end
                        end
                        default: begin
                            rx_pos_s = 2'd0;
                        end
                    endcase
                end else begin
                    state_s = WAIT_RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; handshake outputs decode the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            op_write_r  <= 1'b0;
            addr_r      <= {ADDRESS_BITS{1'b0}};
            data_r      <= {DATA_WIDTH{1'b0}};
            dest_r      <= {ID_BITS{1'b0}};
            rx_pos_r    <= 2'd0;
            discard_r   <= 1'b0;
            resp_addr_r <= {ADDRESS_BITS{1'b0}};
            tx_flit_r   <= {(DATA_WIDTH+2){1'b0}};
            tx_valid_r  <= 1'b0;
            rx_ready_r  <= 1'b0;
            ready_r     <= 1'b1;
            dvalid_r    <= 1'b0;
            daddr_r     <= {ADDRESS_BITS{1'b0}};
            ddata_r     <= {DATA_WIDTH{1'b0}};
            proto_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            op_write_r  <= op_write_s;
            addr_r      <= addr_s;
            data_r      <= data_s;
            dest_r      <= dest_s;
            rx_pos_r    <= rx_pos_s;
            discard_r   <= discard_s;
            resp_addr_r <= resp_addr_s;
            tx_flit_r   <= tx_flit_s;
            tx_valid_r  <= (state_s == HEAD) || (state_s == ADDR) || (state_s == DATA);
            rx_ready_r  <= (state_s == WAIT_RESP);
            ready_r     <= (state_s == IDLE);
            dvalid_r    <= dvalid_s;
            daddr_r     <= daddr_s;
            ddata_r     <= ddata_s;
            proto_err_r <= proto_err_s;
        end
    end

    assign net2core_dReady = ready_r;
    assign net2core_dValid = dvalid_r;
    assign net2core_dAddr  = daddr_r;
    assign net2core_dData  = ddata_r;
    assign tx_flit         = tx_flit_r;
    assign tx_valid        = tx_valid_r;
    assign rx_ready        = rx_ready_r;
    assign proto_err       = proto_err_r;

endmodule

// File: tb/tb_ra_net_interface.sv
// Scoreboard bench for ra_net_interface: stimulus pushes expected tx flits and
// read returns into queues; a negedge monitor pops and compares them.
module tb_ra_net_interface;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int IDB  = 4;
    localparam int RAB  = 16;
    localparam int CORE = 0;

    logic          clock = 1'b0;
    logic          reset;
    logic          core2net_dRead, core2net_dWrite;
    logic [AW-1:0] core2net_dAddr;
    logic [DW-1:0] core2net_dData;
    logic          net2core_dReady, net2core_dValid;
    logic [AW-1:0] net2core_dAddr;
    logic [DW-1:0] net2core_dData;
    logic [DW+1:0] tx_flit;
    logic          tx_valid, tx_ready;
    logic [DW+1:0] rx_flit;
    logic          rx_valid, rx_ready, proto_err;

    always #5 clock = ~clock;

    ra_net_interface #(.CORE(CORE), .ID_BITS(IDB), .REAL_ADDR_BITS(RAB),
                       .DATA_WIDTH(DW), .ADDRESS_BITS(AW)) dut (
        .clock(clock), .reset(reset),
        .core2net_dRead(core2net_dRead), .core2net_dWrite(core2net_dWrite),
        .core2net_dAddr(core2net_dAddr), .core2net_dData(core2net_dData),
        .net2core_dReady(net2core_dReady), .net2core_dValid(net2core_dValid),
        .net2core_dAddr(net2core_dAddr), .net2core_dData(net2core_dData),
        .tx_flit(tx_flit), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_flit(rx_flit), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .proto_err(proto_err)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW+1:0] exp_tx_q[$];
    logic [AW-1:0] exp_raddr_q[$];
    logic [DW-1:0] exp_rdata_q[$];
    logic          exp_perr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Head flit from the packet rules: dest, src, opcode packed by place value.
    function automatic logic [DW+1:0] head_flit(input int dst, input int src, input int opc);
        logic [DW-1:0] p;
        p = DW'(opc * (2 ** (2 * IDB)) + src * (2 ** IDB) + dst);
        return {2'b01, p};
    endfunction

    // Monitor: pops expectations whenever the DUT presents a flit or a read return.
    initial begin
        logic          prev_stall;
        logic [DW+1:0] prev_flit;
        logic [DW+1:0] e;
        prev_stall = 1'b0;
        prev_flit  = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && tx_valid) check("tx_hold", 64'(tx_flit), 64'(prev_flit));
                if (tx_valid && tx_ready) begin
                    if (exp_tx_q.size() == 0) fail_now("tx_unexpected_flit");
                    else begin
                        e = exp_tx_q.pop_front();
                        check("tx_flit", 64'(tx_flit), 64'(e));
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_flit  = tx_flit;
                if (net2core_dValid) begin
                    if (exp_raddr_q.size() == 0) fail_now("unexpected_dValid");
                    else begin
                        check("dAddr", 64'(net2core_dAddr), 64'(exp_raddr_q.pop_front()));
                        check("dData", 64'(net2core_dData), 64'(exp_rdata_q.pop_front()));
                    end
                end
            end
        end
    end

    // Present one rx flit after a random idle gap; returns #1 after the accepting edge.
    task automatic send_rx(input logic [DW+1:0] f);
        repeat ($urandom_range(0, 2)) begin
            rx_valid = 1'b0;
            rx_flit  = {2'($urandom), 32'($urandom)};
            @(posedge clock); #1;
        end
        rx_flit  = f;
        rx_valid = 1'b1;
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    // Issue a request, send it out, optionally inject a bad packet, then a good reply.
    task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int bad, input logic stall_addr, input logic bp, input int bad_src);
        int            cnt;
        int            dest;
        int            stall_cnt;
        int            src;
        logic [DW+1:0] addr_flit;
        dest = int'((addr / (2 ** RAB)) % (2 ** IDB));
        cnt  = 0;
        while (!net2core_dReady && cnt < 100) begin
            @(posedge clock); #1;
            cnt++;
        end
        if (!net2core_dReady) begin
            fail_now("ready_timeout");
            return;
        end
        addr_flit = {(wr ? 2'b00 : 2'b10), addr};
        exp_tx_q.push_back(head_flit(dest, CORE, wr ? 2 : 1));
        exp_tx_q.push_back(addr_flit);
        if (wr) exp_tx_q.push_back({2'b10, data});
        core2net_dWrite = wr;
        core2net_dRead  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        core2net_dAddr  = addr;
        core2net_dData  = data;
        rx_valid        = 1'b1;
        rx_flit         = {2'($urandom), 32'($urandom)};
        @(posedge clock); #1;
        core2net_dRead  = 1'b0;
        core2net_dWrite = 1'b0;
        core2net_dAddr  = $urandom;
        core2net_dData  = $urandom;
        check("head_next_cycle", 64'(tx_valid), 64'(1));
        check("ready_low_busy", 64'(net2core_dReady), 64'(0));
        cnt       = 0;
        stall_cnt = 0;
        while (!rx_ready && cnt < 200) begin
            if (stall_addr && stall_cnt < 5 && tx_valid && tx_flit == addr_flit) begin
                tx_ready = 1'b0;
                stall_cnt++;
            end else if (bp) tx_ready = ($urandom_range(0, 3) != 0);
            else tx_ready = 1'b1;
            rx_valid = 1'($urandom_range(0, 1));
            rx_flit  = {2'($urandom), 32'($urandom)};
            @(posedge clock); #1;
            cnt++;
        end
        rx_valid = 1'b0;
        if (!rx_ready) begin
            fail_now("rx_ready_timeout");
            return;
        end
        if (stall_addr) check("addr_stall_cycles", 64'(stall_cnt), 64'(5));
        check("tx_all_sent", 64'(exp_tx_q.size()), 64'(0));
        if (bad == 1) begin
            src = (bad_src >= 0) ? bad_src : (dest + 1 + $urandom_range(0, 14)) % 16;
            send_rx(head_flit(CORE, src, wr ? 0 : 3));
            if (wr) send_rx({2'b10, addr});
            else begin
                send_rx({2'b00, addr});
                send_rx({2'b10, 32'($urandom)});
            end
            exp_perr = 1'b1;
        end else if (bad == 2) begin
            send_rx({2'b00, 32'($urandom)});
            send_rx({2'b10, 32'($urandom)});
            exp_perr = 1'b1;
        end
        send_rx(head_flit(CORE, dest, wr ? 0 : 3));
        if (wr) send_rx({2'b10, addr});
        else begin
            send_rx({2'b00, addr});
            exp_raddr_q.push_back(addr);
            exp_rdata_q.push_back(data);
            send_rx({2'b10, data});
        end
        check("ready_after_resp", 64'(net2core_dReady), 64'(1));
        check("rx_ready_after_resp", 64'(rx_ready), 64'(0));
        check("proto_err", 64'(proto_err), 64'(exp_perr));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        reset = 1'b1;
        core2net_dRead = 1'b0; core2net_dWrite = 1'b0;
        core2net_dAddr = '0;   core2net_dData  = '0;
        tx_ready = 1'b1; rx_valid = 1'b0; rx_flit = '0;
        exp_perr = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_dReady", 64'(net2core_dReady), 64'(1));
        check("rst_dValid", 64'(net2core_dValid), 64'(0));
        check("rst_dAddr", 64'(net2core_dAddr), 64'(0));
        check("rst_dData", 64'(net2core_dData), 64'(0));
        check("rst_tx_valid", 64'(tx_valid), 64'(0));
        check("rst_tx_flit", 64'(tx_flit), 64'(0));
        check("rst_rx_ready", 64'(rx_ready), 64'(0));
        check("rst_proto_err", 64'(proto_err), 64'(0));
        reset = 1'b0;
        @(posedge clock); #1;

        // Directed read and write from the packet examples, then ADDR stall.
        do_txn(1'b0, 32'h0003_0040, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, -1);
        do_txn(1'b1, 32'h0005_0010, 32'h0000_1234, 0, 1'b0, 1'b0, -1);
        do_txn(1'b0, 32'h0007_0100, 32'hCAFE_0001, 0, 1'b1, 1'b0, -1);
        do_txn(1'b1, 32'h0009_0200, 32'h5555_AAAA, 0, 1'b1, 1'b0, -1);
        // Bad head (src 7 for a request to core 3), then a correct reply.
        do_txn(1'b0, 32'h0003_0080, 32'h0BAD_F00D, 1, 1'b0, 1'b0, 7);
        // Randomized traffic with backpressure and occasional bad packets.
        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0,
                   1'b0, 1'b1, -1);
        end

        // Reset in WAIT_RESP: outputs drop at once, late reply ignored.
        cnt = 0;
        while (!net2core_dReady && cnt < 100) begin
            @(posedge clock); #1;
            cnt++;
        end
        exp_tx_q.push_back(head_flit(5, CORE, 1));
        exp_tx_q.push_back({2'b10, 32'h0005_0044});
        core2net_dRead = 1'b1;
        core2net_dAddr = 32'h0005_0044;
        tx_ready       = 1'b1;
        @(posedge clock); #1;
        core2net_dRead = 1'b0;
        cnt = 0;
        while (!rx_ready && cnt < 50) begin
            @(posedge clock); #1;
            cnt++;
        end
        check("reset_test_wait_resp", 64'(rx_ready), 64'(1));
        send_rx(head_flit(CORE, 5, 3));
        reset = 1'b1;
        #1;
        check("midrst_dReady", 64'(net2core_dReady), 64'(1));
        check("midrst_rx_ready", 64'(rx_ready), 64'(0));
        check("midrst_tx_valid", 64'(tx_valid), 64'(0));
        check("midrst_proto_err", 64'(proto_err), 64'(0));
        exp_perr = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        send_rx({2'b00, 32'h0005_0044});
        send_rx({2'b10, 32'h1111_2222});
        @(posedge clock); #1;
        check("late_resp_ignored_ready", 64'(net2core_dReady), 64'(1));
        check("late_resp_ignored_perr", 64'(proto_err), 64'(0));

        // Normal operation after reset.
        do_txn(1'b0, 32'h000A_1234, 32'h0F0F_F0F0, 0, 1'b0, 1'b1, -1);
        do_txn(1'b1, 32'h000B_4321, 32'h8000_0001, 0, 1'b0, 1'b1, -1);
        @(posedge clock); #1;
        check("rsp_queue_drained", 64'(exp_raddr_q.size()), 64'(0));
        check("final_dValid_low", 64'(net2core_dValid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ra_net_interface.md
# ra_net_interface

Converts remote data-side requests into network packets and reassembles the replies. Each remote request is a read or write whose address names another core, and the block serializes it into head/address/data flits on the router injection port. It then collects the matching response packet and returns it on the net2core_d* return path. It sits directly downstream of the core-side remote-access splitter: it consumes core2net_d* and produces net2core_d*. At most one transaction is outstanding at a time.

## Interface
Parameters:
- CORE, 0, this core's ID; used as the source field in every head flit.
- ID_BITS, 4, width of a core ID.
- REAL_ADDR_BITS, 16, local address bits; destination = addr[REAL_ADDR_BITS+ID_BITS-1:REAL_ADDR_BITS].
- DATA_WIDTH, 32, data and flit payload width; must be ≥ 2*ID_BITS+2.
- ADDRESS_BITS, 32, address width.

Ports:
- clock  in  1  single clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high.
- core2net_dRead  in  1  read request; sampled only while net2core_dReady=1.
- core2net_dWrite  in  1  write request; sampled only while net2core_dReady=1.
- core2net_dAddr  in  ADDRESS_BITS  request address.
- core2net_dData  in  DATA_WIDTH  write data.
- net2core_dReady  out  1  high only in IDLE.
- net2core_dValid  out  1  one-cycle pulse when read data is returned.
- net2core_dAddr  out  ADDRESS_BITS  address of returned read.
- net2core_dData  out  DATA_WIDTH  returned read data.
- tx_flit  out  DATA_WIDTH+2  injection flit, {type[1:0], payload}.
- tx_valid  out  1  tx_flit valid.
- tx_ready  in  1  router accepts tx_flit.
- rx_flit  in  DATA_WIDTH+2  ejection flit.
- rx_valid  in  1  rx_flit valid.
- rx_ready  out  1  high only in WAIT_RESP.
- proto_err  out  1  sticky; set by any malformed or mismatched response; cleared only by reset.

## Operation
Flit format:
- Flit types: 01 head, 00 body, 10 tail.
- Head payload fields: [ID_BITS-1:0] dest, [2*ID_BITS-1:ID_BITS] src, [2*ID_BITS+1:2*ID_BITS] opcode. All other payload bits are 0.
- Opcodes: 01 read request, 10 write request, 11 read response, 00 write ack.

Packet shapes:
- Read request: head, then address (tail).
- Write request: head, address (body), data (tail).
- Read response: head, address (body), data (tail).
- Write ack: head, address (tail).

FSM states: IDLE, HEAD, ADDR, DATA, WAIT_RESP.
- IDLE: if read or write is high, latch op, address, data and dest; go to HEAD. If both read and write are high, treat as a write.
- HEAD: drive the head flit. On tx_valid&tx_ready go to ADDR.
- ADDR: drive the address flit, type tail for a read, body for a write. On accept go to WAIT_RESP (read) or DATA (write).
- DATA: drive the data flit as tail. On accept go to WAIT_RESP.
- WAIT_RESP: accept rx flits in sequence: head, address, data (read) or head, address (write).
  - A valid head has dest==CORE, src==latched dest, and opcode 11 for a read or 00 for a write.
  - Any mismatch sets proto_err. A bad head, or a wrong flit type at any position (including a non-head first flit), also discards the remaining flits up to and including the next tail. The block stays in WAIT_RESP and waits for a fresh head.
  - When a correct tail is accepted, go to IDLE.
  - Read: register the address and data, and pulse net2core_dValid on the next cycle.
  - Write ack: return to IDLE with no dValid.

Outputs:
- tx_valid is high in HEAD, ADDR and DATA only.
- tx_flit holds steady while tx_valid=1 && tx_ready=0.

## Timing
- Reset values: state IDLE; net2core_dReady=1, net2core_dValid=0, net2core_dAddr=0, net2core_dData=0; tx_valid=0, tx_flit=0; rx_ready=0; proto_err=0.
- Request sampled at edge N; head flit on tx at N+1. With tx_ready held high, the tail of a read leaves at N+2 and the tail of a write at N+3.
- Read: response tail accepted at edge M → net2core_dValid=1 and net2core_dReady=1 during cycle M+1. A new request in that same cycle is accepted.
- Write: ack tail accepted at edge M → net2core_dReady=1 during cycle M+1.
- tx_ready low stalls the FSM indefinitely with no flit loss. rx_valid while rx_ready=0 is ignored.
- Reset asserted mid-transaction: outputs return to reset values immediately, and the in-flight packet is abandoned.

## Test plan
- Remote read, CORE=0, addr 0x0003_0040, tx_ready=1:
  - tx flits {01,0x00000103}, {10,0x00030040}.
  - Reply {01,0x00000330}, {00,0x00030040}, {10,0xDEADBEEF} → one-cycle dValid with dAddr 0x00030040, dData 0xDEADBEEF.
- Remote write, addr 0x0005_0010, data 0x1234:
  - tx flits {01,0x00000205}, {00,0x00050010}, {10,0x00001234}.
  - Ack {01,0x00000050}, {10,0x00050010} → dReady=1, dValid stays 0.
- tx backpressure: hold tx_ready=0 for 5 cycles during ADDR → the same flit is held stable, then sent exactly once.
- Bad response: reply head src=7 to a request sent to dest 3 → proto_err=1. Its flits are dropped; a correct response afterwards completes normally.
- Back-to-back: a new read presented in the dValid cycle → its head appears on the next cycle.
- Reset asserted during WAIT_RESP → dReady=1, rx_ready=0, tx_valid=0 immediately; a late response is ignored.
